// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp codes and default phase durations shared by the
// phase sequencer and the lamp drivers.
package traffic_pkg;

  typedef enum logic [3:0] {
    ST_BOOT = 4'd0,
    ST_NS_G = 4'd1,
    ST_NS_Y = 4'd2,
    ST_AR_A = 4'd3,
    ST_EW_G = 4'd4,
    ST_EW_Y = 4'd5,
    ST_AR_B = 4'd6,
    ST_EMG  = 4'd7,
    ST_WALK = 4'd15   // code 7 with the walk bit set
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int DEF_W        = 8;
  localparam int DEF_T_GREEN  = 5;
  localparam int DEF_T_YELLOW = 2;
  localparam int DEF_T_ALLRED = 1;
  localparam int DEF_T_WALK   = 4;

  // {ns_light, ew_light} for a state; everything not green/yellow is all red
  function automatic logic [5:0] lights_of(state_t s);
    case (s)
      ST_NS_G: lights_of = {LIGHT_GRN, LIGHT_RED};
      ST_NS_Y: lights_of = {LIGHT_YEL, LIGHT_RED};
      ST_EW_G: lights_of = {LIGHT_RED, LIGHT_GRN};
      ST_EW_Y: lights_of = {LIGHT_RED, LIGHT_YEL};
      default: lights_of = {LIGHT_RED, LIGHT_RED};
    endcase
  endfunction

endpackage

// File: rtl/ped_request_latch.sv
// ped_request_latch: holds a pedestrian button press until the walk phase takes it.
// Latency: pending rises on the edge after set; clear wins over a same-cycle set.
// Backpressure: none; repeated presses while pending collapse into one request.
module ped_request_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic pending
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pending <= 1'b0;
    else if (clr) pending <= 1'b0;
    else if (set) pending <= 1'b1;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: NS/EW phase sequencer driving the countdown timer; PED_WALK_EN adds a walk phase.
// Latency: state, lamps and timer_start/timer_load update on the edge after enable && timer_done.
// Backpressure: enable=0 freezes state and suppresses timer_start; timer_done in a timer_start cycle is ignored.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_WALK   = DEF_T_WALK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         timer_done,
  input  logic         emergency,
`ifdef PED_WALK_EN
  input  logic         ped_req,
`endif
  output logic         timer_start,
  output logic [W-1:0] timer_load,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic         walk,
  output logic [2:0]   phase,
  output logic         ped_pending
);

  localparam logic [W-1:0] LD_GREEN  = W'(T_GREEN);
  localparam logic [W-1:0] LD_YELLOW = W'(T_YELLOW);
  localparam logic [W-1:0] LD_ALLRED = W'(T_ALLRED);
  localparam logic [W-1:0] LD_WALK   = W'(T_WALK);

  state_t         state, state_nxt;
  logic           start_nxt;
  logic [W-1:0]   load_nxt;
  logic           done_ok;
  logic           pending;

  // the timer has not reloaded yet during the strobe cycle, so its done is stale
  assign done_ok = timer_done && !timer_start;

`ifdef PED_WALK_EN
  logic ped_clr;
  assign ped_clr = (state_nxt == ST_WALK) && (state != ST_WALK);

  ped_request_latch u_ped_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (ped_req),
    .clr     (ped_clr),
    .pending (pending)
  );
`else
  assign pending = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load_nxt  = timer_load;
    if (enable) begin
      case (state)
        ST_BOOT: begin
          state_nxt = ST_AR_B;
          load_nxt  = LD_ALLRED;
        end
        ST_NS_G: if (emergency || done_ok) begin
          state_nxt = ST_NS_Y;
          load_nxt  = LD_YELLOW;
        end
        ST_NS_Y: if (done_ok) begin
          state_nxt = ST_AR_A;
          load_nxt  = LD_ALLRED;
        end
        ST_AR_A: if (done_ok) begin
          if (emergency) state_nxt = ST_EMG;
          else begin
            state_nxt = ST_EW_G;
            load_nxt  = LD_GREEN;
          end
        end
        ST_EW_G: if (emergency || done_ok) begin
          state_nxt = ST_EW_Y;
          load_nxt  = LD_YELLOW;
        end
        ST_EW_Y: if (done_ok) begin
          state_nxt = ST_AR_B;
          load_nxt  = LD_ALLRED;
        end
        ST_AR_B: if (done_ok) begin
          if (emergency) state_nxt = ST_EMG;
          else if (pending) begin
            state_nxt = ST_WALK;
            load_nxt  = LD_WALK;
          end else begin
            state_nxt = ST_NS_G;
            load_nxt  = LD_GREEN;
          end
        end
        ST_WALK: if (done_ok) begin
          state_nxt = ST_NS_G;
          load_nxt  = LD_GREEN;
        end
        ST_EMG: if (!emergency) begin
          state_nxt = ST_AR_B;
          load_nxt  = LD_ALLRED;
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
    // EMG is untimed: it is held by the emergency level, not the timer
    start_nxt = (state_nxt != state) && (state_nxt != ST_EMG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      timer_start <= 1'b0;
      timer_load  <= '0;
    end else begin
      state       <= state_nxt;
      timer_start <= start_nxt;
      timer_load  <= load_nxt;
    end
  end

  assign {ns_light, ew_light} = lights_of(state);
  assign walk        = (state == ST_WALK);
  assign phase       = state[2:0];
  assign ped_pending = pending;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural countdown timer ticking every 4 clocks;
// the walk scenario is exercised when PED_WALK_EN is defined.
module tb_traffic_phase_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, enable, timer_done, emergency;
  logic         timer_start;
  logic [W-1:0] timer_load;
  logic [2:0]   ns_light, ew_light, phase;
  logic         walk, ped_pending;
`ifdef PED_WALK_EN
  logic         ped_req;
`endif

  int vectors = 0;
  int miscompares = 0;

  // behavioural timer: loads on timer_start, counts down on every 4th clock
  logic         model_done, done_force;
  logic [1:0]   tick_cnt;
  logic [W-1:0] tcnt;

  always #5 clk = ~clk;
  assign timer_done = model_done | done_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= 2'd0;
      tcnt       <= '0;
      model_done <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt + 2'd1;
      model_done <= 1'b0;
      if (timer_start) tcnt <= timer_load;
      else if (enable && tick_cnt == 2'd3 && tcnt != '0) begin
        tcnt <= tcnt - 1'b1;
        if (tcnt == 8'd1) model_done <= 1'b1;
      end
    end
  end

  traffic_phase_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .timer_done  (timer_done),
    .emergency   (emergency),
`ifdef PED_WALK_EN
    .ped_req     (ped_req),
`endif
    .timer_start (timer_start),
    .timer_load  (timer_load),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  // waits for the next timer_start; cycles = clock edges since the previous sample
  task automatic wait_start(input int budget, output int cycles, output bit found);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (timer_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_phase_start(input logic [2:0] want);
    int c; bit f;
    for (int k = 0; k < 8; k++) begin
      wait_start(200, c, f);
      if (f && phase === want) break;
    end
    vectors++;
    if (phase !== want || timer_start !== 1'b1) begin
      $display("FAIL reach_phase: phase=%0d start=%b required phase=%0d start=1", phase, timer_start, want);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; emergency = 1'b0; done_force = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
    #12;
    vectors++;
    if ({phase, ns_light, ew_light, walk, timer_start, timer_load, ped_pending} !== {3'd0, 3'b100, 3'b100, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      $display("FAIL reset_values: phase=%0d ns=%b ew=%b walk=%b start=%b load=%0d pend=%b required 0,100,100,0,0,0,0",
               phase, ns_light, ew_light, walk, timer_start, timer_load, ped_pending);
      miscompares++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (phase !== 3'd0 || timer_start !== 1'b0) begin
      $display("FAIL boot_hold_disabled: phase=%0d start=%b required 0,0", phase, timer_start);
      miscompares++;
    end
  endtask

  task automatic test_boot;
    int c; bit f;
    enable = 1'b1;
    wait_start(10, c, f);
    vectors++;
    if (!f || phase !== 3'd6 || timer_load !== 8'd1 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
      $display("FAIL boot_to_ar_b: found=%b phase=%0d load=%0d ns=%b ew=%b required 1,6,1,100,100", f, phase, timer_load, ns_light, ew_light);
      miscompares++;
    end
    wait_start(40, c, f);
    vectors++;
    if (!f || phase !== 3'd1 || timer_load !== 8'd5 || ns_light !== 3'b001 || ew_light !== 3'b100) begin
      $display("FAIL ar_b_to_ns_g: found=%b phase=%0d load=%0d ns=%b ew=%b required 1,1,5,001,100", f, phase, timer_load, ns_light, ew_light);
      miscompares++;
    end
    vectors++;
    if (c < 3 || c > 6) begin
      $display("FAIL ar_b_length: %0d clocks, required 3..6", c);
      miscompares++;
    end
  endtask

  task automatic test_full_cycle;
    logic [2:0] exp_phase [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    logic [7:0] exp_load  [6] = '{8'd2, 8'd1, 8'd5, 8'd2, 8'd1, 8'd5};
    logic [2:0] exp_ns    [6] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] exp_ew    [6] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    int         prev_dur  [6] = '{5, 2, 1, 5, 2, 1};
    int c; bit f;
    for (int i = 0; i < 6; i++) begin
      wait_start(100, c, f);
      vectors++;
      if (!f || phase !== exp_phase[i] || timer_load !== exp_load[i] || ns_light !== exp_ns[i] || ew_light !== exp_ew[i] || walk !== 1'b0) begin
        $display("FAIL cycle_step%0d: found=%b phase=%0d load=%0d ns=%b ew=%b walk=%b required phase=%0d load=%0d ns=%b ew=%b walk=0",
                 i, f, phase, timer_load, ns_light, ew_light, walk, exp_phase[i], exp_load[i], exp_ns[i], exp_ew[i]);
        miscompares++;
      end
      vectors++;
      if (c < 4*prev_dur[i]-1 || c > 4*prev_dur[i]+2) begin
        $display("FAIL cycle_len%0d: %0d clocks, required %0d..%0d", i, c, 4*prev_dur[i]-1, 4*prev_dur[i]+2);
        miscompares++;
      end
    end
  endtask

  task automatic test_emergency;
    int c, starts, bad; bit f;
    repeat (8) @(posedge clk);
    #1 emergency = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (phase !== 3'd2 || timer_start !== 1'b1 || timer_load !== 8'd2) begin
      $display("FAIL emg_to_ns_y: phase=%0d start=%b load=%0d required 2,1,2", phase, timer_start, timer_load);
      miscompares++;
    end
    wait_start(40, c, f);
    vectors++;
    if (!f || phase !== 3'd3 || timer_load !== 8'd1) begin
      $display("FAIL emg_to_ar_a: found=%b phase=%0d load=%0d required 1,3,1", f, phase, timer_load);
      miscompares++;
    end
    f = 1'b0;
    for (int k = 0; k < 40 && !f; k++) begin
      @(posedge clk); #1;
      if (phase === 3'd7) f = 1'b1;
    end
    vectors++;
    if (!f || timer_start !== 1'b0 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
      $display("FAIL emg_enter: found=%b start=%b ns=%b ew=%b required 1,0,100,100", f, timer_start, ns_light, ew_light);
      miscompares++;
    end
    starts = 0; bad = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (timer_start !== 1'b0) starts++;
      if (phase !== 3'd7) bad++;
    end
    vectors++;
    if (starts != 0 || bad != 0) begin
      $display("FAIL emg_hold: %0d strobes, %0d cycles out of EMG, required 0,0", starts, bad);
      miscompares++;
    end
    emergency = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (phase !== 3'd6 || timer_start !== 1'b1 || timer_load !== 8'd1) begin
      $display("FAIL emg_release: phase=%0d start=%b load=%0d required 6,1,1", phase, timer_start, timer_load);
      miscompares++;
    end
  endtask

  task automatic test_ped_walk;
`ifdef PED_WALK_EN
    int c; bit f;
    wait_phase_start(3'd4);
    ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    vectors++;
    if (ped_pending !== 1'b1) begin
      $display("FAIL ped_latch: pending=%b required 1", ped_pending);
      miscompares++;
    end
    wait_phase_start(3'd6);
    // press again on the cycle the walk is entered: it must be absorbed by that walk
    f = 1'b0;
    for (int k = 0; k < 20 && !f; k++) begin
      @(posedge clk); #1;
      if (timer_done === 1'b1) f = 1'b1;
    end
    ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    vectors++;
    if (phase !== 3'd7 || walk !== 1'b1 || timer_start !== 1'b1 || timer_load !== 8'd4 || ped_pending !== 1'b0 ||
        ns_light !== 3'b100 || ew_light !== 3'b100) begin
      $display("FAIL walk_enter: phase=%0d walk=%b start=%b load=%0d pend=%b ns=%b ew=%b required 7,1,1,4,0,100,100",
               phase, walk, timer_start, timer_load, ped_pending, ns_light, ew_light);
      miscompares++;
    end
    wait_start(40, c, f);
    vectors++;
    if (!f || phase !== 3'd1 || walk !== 1'b0 || timer_load !== 8'd5 || ped_pending !== 1'b0 || c < 15 || c > 18) begin
      $display("FAIL walk_exit: found=%b phase=%0d walk=%b load=%0d pend=%b len=%0d required 1,1,0,5,0,15..18",
               f, phase, walk, timer_load, ped_pending, c);
      miscompares++;
    end
`else
    wait_phase_start(3'd1);
    vectors++;
    if (ped_pending !== 1'b0 || walk !== 1'b0) begin
      $display("FAIL no_ped: pend=%b walk=%b required 0,0", ped_pending, walk);
      miscompares++;
    end
`endif
  endtask

  task automatic test_enable_freeze;
    int c; bit f;
    wait_phase_start(3'd2);
    enable = 1'b0;
    done_force = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (phase !== 3'd2 || timer_start !== 1'b0) begin
        $display("FAIL freeze_clk%0d: phase=%0d start=%b required 2,0", k, phase, timer_start);
        miscompares++;
      end
    end
    enable = 1'b1;
    done_force = 1'b0;
    wait_start(40, c, f);
    vectors++;
    if (!f || phase !== 3'd3 || timer_load !== 8'd1) begin
      $display("FAIL freeze_resume: found=%b phase=%0d load=%0d required 1,3,1", f, phase, timer_load);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    int c; bit f;
    wait_phase_start(3'd5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({phase, ns_light, ew_light, walk, timer_start, timer_load, ped_pending} !== {3'd0, 3'b100, 3'b100, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      $display("FAIL midreset_values: phase=%0d ns=%b ew=%b walk=%b start=%b load=%0d pend=%b required 0,100,100,0,0,0,0",
               phase, ns_light, ew_light, walk, timer_start, timer_load, ped_pending);
      miscompares++;
    end
    #3 rst_n = 1'b1;
    wait_start(3, c, f);
    vectors++;
    if (!f || phase !== 3'd6 || timer_load !== 8'd1) begin
      $display("FAIL midreset_reboot: found=%b phase=%0d load=%0d required 1,6,1", f, phase, timer_load);
      miscompares++;
    end
    // a done during the strobe cycle is stale and must not advance the phase
    done_force = 1'b1;
    @(posedge clk); #1 done_force = 1'b0;
    vectors++;
    if (phase !== 3'd6 || timer_start !== 1'b0) begin
      $display("FAIL done_in_start_cycle: phase=%0d start=%b required 6,0", phase, timer_start);
      miscompares++;
    end
    wait_start(40, c, f);
    vectors++;
    if (!f || phase !== 3'd1 || timer_load !== 8'd5) begin
      $display("FAIL midreset_ns_g: found=%b phase=%0d load=%0d required 1,1,5", f, phase, timer_load);
      miscompares++;
    end
  endtask

  initial begin
    test_reset;
    test_boot;
    test_full_cycle;
    test_emergency;
    test_ped_walk;
    test_enable_freeze;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
